// File: rtl/exec_ctrl.sv
// Fetch/execute sequencer driving the 8-bit ALU: fetch over req/ack, one-cycle EXEC, HALT.
// Optional single-step gating of fetches when EXEC_CTRL_STEP_EN is defined (adds the step port).
module exec_ctrl #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [11:0]     imem_data,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [3:0]      alu_sel,
    input  logic [7:0]      alu_res,
    input  logic            alu_cout,
    input  logic [7:0]      in_port,
`ifdef EXEC_CTRL_STEP_EN
    input  logic            step,
`endif
    output logic [7:0]      acc,
    output logic            flag_z,
    output logic            flag_c,
    output logic [7:0]      out_port,
    output logic            out_stb,
    output logic            halted
);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_IN,  OP_AND, OP_OR,  OP_XOR, OP_NOT, OP_JMP,
        OP_JZ,  OP_JC,  OP_OUT, OP_ADD, OP_NOPC, OP_NOPD, OP_NOPE, OP_HLT
    } op_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [11:0]     ir, ir_n;
    logic [7:0]      acc_n, out_port_n;
    logic            z_n, c_n, stb_n, req_n;
    op_t             op;
    logic [PC_W-1:0] target;

`ifdef EXEC_CTRL_STEP_EN
    logic armed, armed_n;
`endif

    assign op        = op_t'(ir[11:8]);
    assign target    = PC_W'(ir[7:0]);
    assign imem_addr = pc;
    assign alu_a     = acc;
    assign halted    = (state == HALT);

    always_comb begin
        alu_sel = '0;
        alu_b   = '0;
        if (state == EXEC) begin
            alu_sel = ir[11:8];
            alu_b   = (op == OP_IN) ? in_port : ir[7:0];
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        acc_n      = acc;
        z_n        = flag_z;
        c_n        = flag_c;
        out_port_n = out_port;
        stb_n      = 1'b0;
        case (state)
            FETCH: begin
                if (imem_req && imem_ack) begin
                    ir_n    = imem_data;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                state_n = FETCH;
                pc_n    = pc + PC_W'(1);
                case (op)
                    OP_LDI, OP_IN, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                        acc_n = alu_res;
                        z_n   = (alu_res == '0);
                    end
                    OP_ADD: begin
                        acc_n = alu_res;
                        z_n   = (alu_res == '0);
                        c_n   = alu_cout;
                    end
                    OP_JMP: pc_n = target;
                    OP_JZ:  if (flag_z) pc_n = target;
                    OP_JC:  if (flag_c) pc_n = target;
                    OP_OUT: begin
                        out_port_n = acc;
                        stb_n      = 1'b1;
                    end
                    OP_HLT: begin
                        state_n = HALT;
                        pc_n    = pc;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        // req is registered, so it is computed from the state being entered
`ifdef EXEC_CTRL_STEP_EN
        armed_n = armed;
        if (state == FETCH) begin
            if (imem_req && imem_ack) armed_n = 1'b0;
            else if (step)            armed_n = 1'b1;
        end
        req_n = (state_n == FETCH) && armed_n;
`else
        req_n = (state_n == FETCH);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            acc      <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            out_port <= '0;
            out_stb  <= 1'b0;
            imem_req <= 1'b0;
`ifdef EXEC_CTRL_STEP_EN
            armed    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            acc      <= acc_n;
            flag_z   <= z_n;
            flag_c   <= c_n;
            out_port <= out_port_n;
            out_stb  <= stb_n;
            imem_req <= req_n;
`ifdef EXEC_CTRL_STEP_EN
            armed    <= armed_n;
`endif
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: program memory responder with programmable ack delay and ALU model.
// Step-mode scenario runs only when EXEC_CTRL_STEP_EN is defined.
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [11:0] imem_data;
    logic [7:0]  alu_a, alu_b, alu_res;
    logic [3:0]  alu_sel;
    logic        alu_cout;
    logic [7:0]  in_port = 8'h00;
    logic [7:0]  acc, out_port;
    logic        flag_z, flag_c, out_stb, halted;
`ifdef EXEC_CTRL_STEP_EN
    logic        step = 1'b1;
`endif

    logic [11:0] mem [256];
    logic [7:0]  addr_log [$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    exec_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res), .alu_cout(alu_cout),
        .in_port(in_port),
`ifdef EXEC_CTRL_STEP_EN
        .step(step),
`endif
        .acc(acc), .flag_z(flag_z), .flag_c(flag_c),
        .out_port(out_port), .out_stb(out_stb), .halted(halted)
    );

    // ALU environment model
    always_comb begin
        alu_res  = 8'h00;
        alu_cout = 1'b0;
        case (alu_sel)
            4'h1, 4'h2: alu_res = alu_b;
            4'h3: alu_res = alu_a & alu_b;
            4'h4: alu_res = alu_a | alu_b;
            4'h5: alu_res = alu_a ^ alu_b;
            4'h6: alu_res = ~alu_b;
            4'hB: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
            default: ;
        endcase
    end

    // Program memory: ack after ack_delay stall cycles of req
    assign imem_ack  = imem_req && (wait_cnt == ack_delay);
    assign imem_data = mem[imem_addr];

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
        if (!rst && imem_req && imem_ack) addr_log.push_back(imem_addr);
    end

    task automatic fill_hlt();
        for (int i = 0; i < 256; i++) mem[i] = 12'hF00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        addr_log.delete();
    endtask

    task automatic run_to_halt(input int max_cycles);
        int n = 0;
        while (!halted && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic bit log_is(input logic [7:0] e[$]);
        if (addr_log.size() != e.size()) return 1'b0;
        foreach (e[i]) if (addr_log[i] !== e[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        fill_hlt();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", imem_addr); end
        checks++; if (acc !== 8'h00) begin failures++; $display("FAIL reset_acc got=%h exp=00", acc); end
        checks++; if ({flag_z, flag_c} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {flag_z, flag_c}); end
        checks++; if ({imem_req, out_stb, halted} !== 3'b000) begin failures++; $display("FAIL reset_ctrl req/stb/halt got=%b exp=000", {imem_req, out_stb, halted}); end
        checks++; if ({out_port, alu_sel, alu_b} !== 20'h0) begin failures++; $display("FAIL reset_out got=%h exp=00000", {out_port, alu_sel, alu_b}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int stb_cycles = 0;
        int n = 0;
        fill_hlt();
        mem[0] = 12'h105; mem[1] = 12'hB03; mem[2] = 12'hA00; mem[3] = 12'hF00;
        ack_delay = 0;
        do_reset();
        while (!halted && n < 100) begin
            @(negedge clk);
            if (out_stb) stb_cycles++;
            n++;
        end
        repeat (3) begin @(negedge clk); if (out_stb) stb_cycles++; end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL basic_halted got=%b exp=1", halted); end
        checks++; if (acc !== 8'h08) begin failures++; $display("FAIL basic_acc got=%h exp=08", acc); end
        checks++; if ({flag_z, flag_c} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {flag_z, flag_c}); end
        checks++; if (out_port !== 8'h08) begin failures++; $display("FAIL basic_out_port got=%h exp=08", out_port); end
        checks++; if (stb_cycles != 1) begin failures++; $display("FAIL basic_stb_cycles got=%0d exp=1", stb_cycles); end
        checks++; if (imem_addr !== 8'h03) begin failures++; $display("FAIL basic_pc got=%h exp=03", imem_addr); end
        checks++; if (!log_is('{8'h00, 8'h01, 8'h02, 8'h03})) begin failures++; $display("FAIL basic_fetch_seq got_len=%0d exp_len=4", addr_log.size()); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL halt_req got=%b exp=0", imem_req); end
        // reset out of HALT
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({halted, acc, out_port, imem_addr} !== 25'h0) begin failures++; $display("FAIL halt_reset got=%h exp=0000000", {halted, acc, out_port, imem_addr}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_carry_jc();
        fill_hlt();
        mem[0] = 12'h1FF; mem[1] = 12'hB01; mem[2] = 12'hF00;
        do_reset();
        run_to_halt(100);
        checks++; if ({acc, flag_c, flag_z} !== 10'h003) begin failures++; $display("FAIL add_wrap acc/c/z got=%h exp=003", {acc, flag_c, flag_z}); end
        checks++; if (imem_addr !== 8'h02) begin failures++; $display("FAIL add_pc got=%h exp=02", imem_addr); end
        fill_hlt();
        mem[0] = 12'h1FF; mem[1] = 12'hB01; mem[2] = 12'h910; mem[8'h10] = 12'h300; mem[8'h11] = 12'hF00;
        do_reset();
        run_to_halt(100);
        checks++; if (!log_is('{8'h00, 8'h01, 8'h02, 8'h10, 8'h11})) begin failures++; $display("FAIL jc_taken_seq got_len=%0d exp_len=5", addr_log.size()); end
        checks++; if ({acc, flag_c, flag_z} !== 10'h003) begin failures++; $display("FAIL and_keeps_c acc/c/z got=%h exp=003", {acc, flag_c, flag_z}); end
    endtask

    task automatic test_zero_jumps();
        fill_hlt();
        mem[0] = 12'h10F; mem[1] = 12'h50F; mem[2] = 12'h820;
        mem[8'h20] = 12'h600; mem[8'h21] = 12'h830; mem[8'h22] = 12'hF00;
        do_reset();
        run_to_halt(100);
        checks++; if (!log_is('{8'h00, 8'h01, 8'h02, 8'h20, 8'h21, 8'h22})) begin failures++; $display("FAIL jz_seq got_len=%0d exp_len=6", addr_log.size()); end
        checks++; if ({acc, flag_z, flag_c} !== 10'h3FC) begin failures++; $display("FAIL not_acc/z/c got=%h exp=3fc", {acc, flag_z, flag_c}); end
        checks++; if (imem_addr !== 8'h22) begin failures++; $display("FAIL jz_not_taken_pc got=%h exp=22", imem_addr); end
    endtask

    task automatic test_ack_delay();
        int n = 0;
        int stalls = 0;
        bit held = 1'b1;
        fill_hlt();
        mem[0] = 12'h1AB; mem[1] = 12'hF00;
        ack_delay = 3;
        do_reset();
        while (!imem_req && n < 20) begin @(negedge clk); n++; end
        while (!imem_ack && stalls < 20) begin
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || acc !== 8'h00) held = 1'b0;
            stalls++;
            @(negedge clk);
        end
        checks++; if (stalls != 3) begin failures++; $display("FAIL ack_stall_cycles got=%0d exp=3", stalls); end
        checks++; if (!held) begin failures++; $display("FAIL ack_wait_hold got=0 exp=1"); end
        @(negedge clk);
        checks++; if ({acc, alu_sel, alu_b} !== 20'h001AB) begin failures++; $display("FAIL exec_alu acc/sel/b got=%h exp=001ab", {acc, alu_sel, alu_b}); end
        @(negedge clk);
        checks++; if (acc !== 8'hAB) begin failures++; $display("FAIL ldi_delayed got=%h exp=ab", acc); end
        // abort the second fetch while it is still waiting for ack
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({acc, imem_addr, imem_req, halted} !== 18'h0) begin failures++; $display("FAIL midwait_reset got=%h exp=00000", {acc, imem_addr, imem_req, halted}); end
        @(negedge clk);
        rst = 1'b0;
        addr_log.delete();
        run_to_halt(100);
        checks++; if (!log_is('{8'h00, 8'h01}) || acc !== 8'hAB) begin failures++; $display("FAIL refetch_after_reset got_len=%0d acc=%h exp_len=2 acc=ab", addr_log.size(), acc); end
        ack_delay = 0;
    endtask

    task automatic test_wrap_in();
        int n = 0;
        fill_hlt();
        mem[0] = 12'h7FF; mem[8'hFF] = 12'h000;
        in_port = 8'hA5;
        do_reset();
        while (addr_log.size() < 1 && n < 50) begin @(negedge clk); n++; end
        mem[0] = 12'h200; mem[1] = 12'hF00;
        run_to_halt(100);
        checks++; if (!log_is('{8'h00, 8'hFF, 8'h00, 8'h01})) begin failures++; $display("FAIL pc_wrap_seq got_len=%0d exp_len=4", addr_log.size()); end
        checks++; if ({acc, flag_z} !== 9'h14A) begin failures++; $display("FAIL in_acc/z got=%h exp=14a", {acc, flag_z}); end
        in_port = 8'h00;
    endtask

`ifdef EXEC_CTRL_STEP_EN
    task automatic test_step();
        bit idle = 1'b1;
        int n;
        fill_hlt();
        mem[0] = 12'h101; mem[1] = 12'hB01; mem[2] = 12'hB01; mem[3] = 12'hB01;
        step = 1'b0;
        do_reset();
        repeat (10) begin @(negedge clk); if (imem_req !== 1'b0) idle = 1'b0; end
        checks++; if (!idle) begin failures++; $display("FAIL step_idle_req got=1 exp=0"); end
        for (int p = 1; p <= 3; p++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            n = 0;
            while (addr_log.size() < p && n < 20) begin @(negedge clk); n++; end
            if (p == 1) begin
                // now in EXEC: this pulse must not arm another fetch
                step = 1'b1;
                @(negedge clk);
                step = 1'b0;
            end
            repeat (8) @(negedge clk);
            checks++; if (addr_log.size() != p || imem_req !== 1'b0) begin failures++; $display("FAIL step_retire p=%0d got=%0d req=%b exp=%0d req=0", p, addr_log.size(), imem_req, p); end
        end
        checks++; if (acc !== 8'h03 || halted !== 1'b0) begin failures++; $display("FAIL step_acc got=%h halted=%b exp=03 halted=0", acc, halted); end
        step = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_jc();
        test_zero_jumps();
        test_ack_delay();
        test_wrap_in();
`ifdef EXEC_CTRL_STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
